// File: rtl/matrix_scan6x6_pkg.sv
// rtl/matrix_scan6x6_pkg.sv - shared geometry and scan state encoding for the 6x6 matrix scanner
package matrix_scan6x6_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 6;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/matrix_scan6x6.sv
// rtl/matrix_scan6x6.sv - row-multiplexed 6x6 LED matrix scanner with tear-free frame shadow
module matrix_scan6x6
    import matrix_scan6x6_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [COLS-1:0] row0,
    input  logic [COLS-1:0] row1,
    input  logic [COLS-1:0] row2,
    input  logic [COLS-1:0] row3,
    input  logic [COLS-1:0] row4,
    input  logic [COLS-1:0] row5,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col,
    output logic            frame_done
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
    localparam logic [2:0] IDX_LAST   = 3'(ROWS - 1);

    state_e                      state_q, state_d;
    logic [2:0]                  idx_q, idx_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [ROWS-1:0][COLS-1:0]   shadow_q, shadow_d;
    logic [ROWS-1:0]             row_sel_q, row_sel_d;
    logic [COLS-1:0]             col_q, col_d;
    logic                        frame_done_q, frame_done_d;

    assign row_sel    = row_sel_q;
    assign col        = col_q;
    assign frame_done = frame_done_q;

    // State, counters, shadow frame and registered outputs; reset blanks the matrix immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            row_sel_q    <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            row_sel_q    <= row_sel_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they line up with it after the edge.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;
        row_sel_d    = '0;
        col_d        = '0;

        if (!en) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            // The whole frame is captured at once, only at the start of row 0's blank gap.
            if (state_q == ST_BLANK && idx_q == 3'd0 && cnt_q == 8'd0) begin
                shadow_d = {row5, row4, row3, row2, row1, row0};
            end

            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d      = ST_BLANK;
                        cnt_d        = '0;
                        idx_d        = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                        frame_done_d = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        if (state_d == ST_DRIVE) begin
            row_sel_d = {{(ROWS-1){1'b0}}, 1'b1} << idx_d;
            col_d     = shadow_d[idx_d];
        end
    end

endmodule

// File: tb/tb_matrix_scan6x6.sv
// tb/tb_matrix_scan6x6.sv - randomized and directed check of matrix_scan6x6 against a frame-position model
module tb_matrix_scan6x6;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [5:0][5:0] row_in;
    logic [5:0]      rs1, col1, rs2, col2;
    logic            fd1, fd2;

    int              n_checks = 0;
    int              n_err    = 0;
    int              c1, c2;
    logic [5:0][5:0] snap1, snap2;
    logic [5:0]      prev1, prev2;

    always #5 clk = ~clk;

    matrix_scan6x6 #(.DWELL(4), .BLANK(1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .row0(row_in[0]), .row1(row_in[1]), .row2(row_in[2]),
        .row3(row_in[3]), .row4(row_in[4]), .row5(row_in[5]),
        .row_sel(rs1), .col(col1), .frame_done(fd1)
    );

    matrix_scan6x6 #(.DWELL(1), .BLANK(1)) dut_fast (
        .clk(clk), .rst(rst), .en(en),
        .row0(row_in[0]), .row1(row_in[1]), .row2(row_in[2]),
        .row3(row_in[3]), .row4(row_in[4]), .row5(row_in[5]),
        .row_sel(rs2), .col(col2), .frame_done(fd2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // c = enabled cycles since the scan (re)started; cycle 0 is the one whose closing edge loads the frame.
    function automatic logic [12:0] model_out(input int c, input int d, input int b,
                                              input logic [5:0][5:0] snap);
        int p, f, r, ph;
        logic [12:0] o;
        p  = 6 * (b + d);
        f  = c % p;
        r  = f / (b + d);
        ph = f % (b + d);
        o  = '0;
        if (ph >= b) begin
            o[11:6] = 6'(1 << r);
            o[5:0]  = snap[r];
        end
        o[12] = (c > 0 && f == 0);
        return o;
    endfunction

    task automatic tick();
        logic [12:0] e1, e2;
        @(posedge clk);
        if (rst) begin
            c1 = 0; c2 = 0; snap1 = '0; snap2 = '0;
        end else if (!en) begin
            c1 = 0; c2 = 0;
        end else begin
            if (c1 % 30 == 0) snap1 = row_in;
            c1++;
            if (c2 % 12 == 0) snap2 = row_in;
            c2++;
        end
        #1;
        e1 = model_out(c1, 4, 1, snap1);
        e2 = model_out(c2, 1, 1, snap2);
        check("row_sel",      32'(rs1),  32'(e1[11:6]));
        check("col",          32'(col1), 32'(e1[5:0]));
        check("frame_done",   32'(fd1),  32'(e1[12]));
        check("row_sel_fast", 32'(rs2),  32'(e2[11:6]));
        check("col_fast",     32'(col2), 32'(e2[5:0]));
        check("frame_done_fast", 32'(fd2), 32'(e2[12]));
        check("onehot",      32'($countones(rs1) <= 1), 32'd1);
        check("onehot_fast", 32'($countones(rs2) <= 1), 32'd1);
        check("gap",      32'(rs1 != 0 && prev1 != 0 && rs1 != prev1), 32'd0);
        check("gap_fast", 32'(rs2 != 0 && prev2 != 0 && rs2 != prev2), 32'd0);
        prev1 = rs1;
        prev2 = rs2;
        @(negedge clk);
    endtask

    task automatic run_until(input logic [5:0] want, input int max);
        int n;
        n = 0;
        while (rs1 !== want && n < max) begin
            tick();
            n++;
        end
        check("wait_row", 32'(rs1), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int first1, first2, nfd1, nfd2, saw_fd;
        logic [5:0] first_rs;

        rst = 1'b1; en = 1'b1; row_in = '0; row_in[0] = 6'b000001;
        c1 = 0; c2 = 0; snap1 = '0; snap2 = '0; prev1 = '0; prev2 = '0;
        @(negedge clk);
        tick();
        tick();
        check("reset_row_sel", 32'(rs1), 32'd0);
        check("reset_col",     32'(col1), 32'd0);
        check("reset_fd",      32'(fd1), 32'd0);

        // Release reset: single lit pixel, first frame timing.
        rst = 1'b0;
        first1 = 0; first2 = 0; nfd1 = 0; nfd2 = 0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k <= 4) begin
                check("first_row_sel", 32'(rs1), 32'd1);
                check("first_col",     32'(col1), 32'd1);
            end
            if (k == 5) check("first_blank", 32'(rs1), 32'd0);
            if (fd1) begin nfd1++; if (first1 == 0) first1 = k; end
            if (fd2) begin nfd2++; if (first2 == 0) first2 = k; end
        end
        check("first_fd_cycle",      32'(first1), 32'd30);
        check("fd_count",            32'(nfd1),   32'd1);
        check("first_fd_cycle_fast", 32'(first2), 32'd12);
        check("fd_count_fast",       32'(nfd2),   32'd2);

        // All pixels lit: order and gap checks run every cycle.
        row_in = {6{6'b111111}};
        for (int k = 0; k < 70; k++) tick();

        // Mid-frame input change must wait for the next frame.
        row_in = '0;
        for (int k = 0; k < 31; k++) tick();
        run_until(6'b000010, 40);
        row_in[3] = 6'b101010;
        run_until(6'b001000, 40);
        check("no_tear_row3", 32'(col1), 32'd0);
        run_until(6'b000001, 40);
        run_until(6'b001000, 40);
        check("next_frame_row3", 32'(col1), 32'b101010);

        // Enable drop while row 4 is driven.
        run_until(6'b010000, 40);
        en = 1'b0;
        tick();
        check("en_drop_row_sel", 32'(rs1), 32'd0);
        check("en_drop_col",     32'(col1), 32'd0);
        tick();
        tick();
        en = 1'b1;
        saw_fd = 0; first_rs = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (fd1) saw_fd = 1;
            if (first_rs == 0) first_rs = rs1;
        end
        check("abort_no_fd",   32'(saw_fd),   32'd0);
        check("restart_row0",  32'(first_rs), 32'd1);

        // Asynchronous reset in the middle of a drive phase.
        row_in = {6{6'b110011}};
        for (int k = 0; k < 31; k++) tick();
        run_until(6'b000100, 40);
        #1 rst = 1'b1;
        #1;
        check("async_row_sel", 32'(rs1),  32'd0);
        check("async_col",     32'(col1), 32'd0);
        check("async_row_sel_fast", 32'(rs2), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        // Randomized frames and enable drops.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 9) < 3) row_in[$urandom_range(0, 5)] = 6'($urandom);
            en = ($urandom_range(0, 99) >= 3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
